// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: R-type funct codes
// and the iterative-engine FSM states.
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_FIX
    } state_t;

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 datapath: 64-bit accumulator, shift-add multiply / restoring divide
// on unsigned magnitudes, plus the 0..31 step counter.
module muldiv_core (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc,
    output logic        last
);

    logic [63:0] acc_q;
    logic [31:0] opb_q;
    logic [4:0]  cnt;
    logic [32:0] madd;
    logic [32:0] rsh;
    logic [33:0] diff;
    logic [63:0] acc_nx;

    // Multiply: add to the upper half, then shift right with carry.
    // Divide: shift remainder:dividend left, trial-subtract the divisor.
    always_comb begin
        madd   = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
        rsh    = {acc_q[63:32], acc_q[31]};
        diff   = {1'b0, rsh} - {2'b00, opb_q};
        acc_nx = acc_q;
        if (is_div) begin
            if (!diff[33])
                acc_nx = {diff[31:0], acc_q[30:0], 1'b1};
            else
                acc_nx = {rsh[31:0], acc_q[30:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_nx = {madd, acc_q[31:1]};
        end else begin
            acc_nx = {1'b0, acc_q[63:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc_q <= {32'h0, opa};
            opb_q <= opb;
            cnt   <= '0;
        end else if (step) begin
            acc_q <= acc_nx;
            cnt   <= cnt + 5'd1;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt == 5'd31);

endmodule

// File: rtl/muldiv.sv
// HI/LO unit: MTHI/MTLO writes, and 34-cycle MULT/MULTU/DIV/DIVU with sign
// handling around an unsigned iterative core.
module muldiv
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [5:0]  Funct,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    state_t      state, state_nx;
    logic        cap, core_load, core_step, fix, wr_hi, wr_lo;
    logic        op_div, op_signed, neg_lo, neg_hi;
    logic [31:0] a_q, b_q;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [63:0] core_acc;
    logic        core_last;
    logic [63:0] prod;
    logic [31:0] fix_hi, fix_lo;

    muldiv_core u_core (
        .CLK    (CLK),
        .RST    (RST),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_div),
        .opa    (mag_a),
        .opb    (mag_b),
        .acc    (core_acc),
        .last   (core_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cap       = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        fix       = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    case (Funct)
                        F_MTHI: wr_hi = 1'b1;
                        F_MTLO: wr_lo = 1'b1;
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            cap      = 1'b1;
                            state_nx = ST_LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                core_load = 1'b1;
                state_nx  = ST_ITER;
            end
            ST_ITER: begin
                core_step = 1'b1;
                if (core_last)
                    state_nx = ST_FIX;
            end
            ST_FIX: begin
                fix      = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign Busy = (state != ST_IDLE);

    always_comb begin
        a_neg  = op_signed & a_q[31];
        b_neg  = op_signed & b_q[31];
        mag_a  = a_neg ? -a_q : a_q;
        mag_b  = b_neg ? -b_q : b_q;
        prod   = neg_lo ? -core_acc : core_acc;
        fix_hi = prod[63:32];
        fix_lo = prod[31:0];
        // Divide by zero bypasses the datapath so signed DIV still returns A in Hi.
        if (op_div) begin
            if (b_q == 32'h0) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = neg_hi ? -core_acc[63:32] : core_acc[63:32];
                fix_lo = neg_lo ? -core_acc[31:0]  : core_acc[31:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q       <= '0;
            b_q       <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
        end else begin
            Done <= fix;
            if (cap) begin
                a_q       <= A;
                b_q       <= B;
                op_div    <= Funct[1];
                op_signed <= ~Funct[0];
            end
            if (core_load) begin
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
            end
            if (wr_hi)
                Hi <= A;
            if (wr_lo)
                Lo <= A;
            if (fix) begin
                Hi <= fix_hi;
                Lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_muldiv;

    localparam logic [5:0] T_MFHI  = 6'h10;
    localparam logic [5:0] T_MTHI  = 6'h11;
    localparam logic [5:0] T_MTLO  = 6'h13;
    localparam logic [5:0] T_MULT  = 6'h18;
    localparam logic [5:0] T_MULTU = 6'h19;
    localparam logic [5:0] T_DIV   = 6'h1A;
    localparam logic [5:0] T_DIVU  = 6'h1B;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] A, B;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    muldiv dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .Funct (Funct),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Hi    (Hi),
        .Lo    (Lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q, r, p;
        longint unsigned ua, ub, uq, ur, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ref_result = '0;
        case (f)
            T_MULT: begin
                p = sa * sb;
                ref_result = p;
            end
            T_MULTU: begin
                up = ua * ub;
                ref_result = up;
            end
            T_DIV: begin
                if (b == 32'h0) ref_result = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_result = {r[31:0], q[31:0]};
                end
            end
            T_DIVU: begin
                if (b == 32'h0) ref_result = {a, 32'hFFFFFFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    ref_result = {ur[31:0], uq[31:0]};
                end
            end
            default: ref_result = '0;
        endcase
    endfunction

    // intr: 0 none, 1 MTLO injected mid-iteration, 2 reset mid-iteration
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int intr);
        logic [63:0] r;
        int          n;
        bit          seen;
        @(negedge CLK);
        Start = 1'b1;
        Funct = f;
        A     = a;
        B     = b;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        if (f == T_MTHI || f == T_MTLO) begin
            if (f == T_MTHI) mhi = a;
            else             mlo = a;
            check("mt_hi", Hi, mhi);
            check("mt_lo", Lo, mlo);
            check("mt_busy", Busy, 0);
            check("mt_done", Done, 0);
            return;
        end
        if (!(f == T_MULT || f == T_MULTU || f == T_DIV || f == T_DIVU)) begin
            @(posedge CLK);
            #1;
            check("ign_busy", Busy, 0);
            check("ign_hi", Hi, mhi);
            check("ign_lo", Lo, mlo);
            return;
        end
        check("busy", Busy, 1);
        r    = ref_result(f, a, b);
        seen = 0;
        for (n = 1; n <= 40; n++) begin
            @(posedge CLK);
            #1;
            if (n == 1) check("done_gap", Done, 0);
            if (intr == 1 && n == 11) begin
                Start = 1'b1;
                Funct = T_MTLO;
                A     = 32'hDEADBEEF;
            end
            if (intr == 1 && n == 12) Start = 1'b0;
            if (intr == 2 && n == 22) begin
                RST = 1'b0;
                #1;
                mhi = '0;
                mlo = '0;
                check("rst_hi", Hi, 0);
                check("rst_lo", Lo, 0);
                check("rst_busy", Busy, 0);
                check("rst_done", Done, 0);
                @(negedge CLK);
                RST = 1'b1;
                @(posedge CLK);
                #1;
                check("rst_idle", Busy, 0);
                return;
            end
            if (n == 33) begin
                check("hold_hi", Hi, mhi);
                check("hold_lo", Lo, mlo);
            end
            if (Done) begin
                seen = 1;
                break;
            end
        end
        check("latency", n, seen ? 34 : 0);
        check("done_busy", Busy, 0);
        mhi = r[63:32];
        mlo = r[31:0];
        check("hi", Hi, mhi);
        check("lo", Lo, mlo);
    endtask

    logic [5:0]  fsel [8];
    logic [31:0] corner [6];

    initial begin
        fsel   = '{T_MTHI, T_MTLO, T_MULT, T_MULTU, T_DIV, T_DIVU, T_MFHI, 6'h05};
        corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
        RST   = 1'b0;
        Start = 1'b0;
        Funct = '0;
        A     = '0;
        B     = '0;
        #12;
        check("reset_hi", Hi, 0);
        check("reset_lo", Lo, 0);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        @(negedge CLK);
        RST = 1'b1;

        run_op(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check("multu_max_hi", Hi, 32'hFFFFFFFE);
        check("multu_max_lo", Lo, 32'h00000001);
        run_op(T_MULT, 32'hFFFFFFFD, 32'd7, 0);
        check("mult_neg_lo", Lo, 32'hFFFFFFEB);
        run_op(T_DIV, 32'hFFFFFFF9, 32'd2, 0);
        check("div_neg_lo", Lo, 32'hFFFFFFFD);
        check("div_neg_hi", Hi, 32'hFFFFFFFF);
        run_op(T_DIVU, 32'd100, 32'd0, 0);
        check("divz_hi", Hi, 32'd100);
        run_op(T_DIV, 32'hFFFFFF9C, 32'd0, 0);
        run_op(T_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_ovf_lo", Lo, 32'h80000000);
        check("div_ovf_hi", Hi, 32'h0);
        run_op(T_MTHI, 32'h12345678, 32'h0, 0);
        run_op(T_MTLO, 32'h9ABCDEF0, 32'h0, 0);
        run_op(T_MFHI, 32'h55555555, 32'h0, 0);
        run_op(T_MULT, 32'h00012345, 32'hFFFF0001, 1);
        run_op(T_DIV, 32'h12345678, 32'h00000123, 2);
        run_op(T_DIVU, 32'd10, 32'd3, 0);
        run_op(T_MULTU, 32'd6, 32'd7, 0);
        check("b2b_lo", Lo, 32'd42);
        run_op(T_MULT, 32'h0, 32'hFFFFFFFF, 0);
        run_op(T_DIV, 32'h0, 32'd5, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
            run_op(fsel[$urandom_range(0, 7)], ra, rb, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
